// File: rtl/l2_arbiter_pkg.sv
// Shared definitions for the two-port L2 bus arbiter: FSM encoding, bus width
// defaults and port indices used by the round-robin last-grant register.
package l2_arbiter_pkg;

  localparam int ADDR_W_DEF = 24;
  localparam int DATA_W_DEF = 32;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_A = 2'd1,
    ST_GRANT_B = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

endpackage

// File: rtl/l2_arb_port.sv
// Per-port front end: start edge detect, pending flag, abort tracking,
// registered read data and the one-cycle completion pulse.
module l2_arb_port #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              grant_i,
  input  logic              active_i,
  input  logic              complete_i,
  input  logic              rd_i,
  input  logic [DATA_W-1:0] l2_q_i,
  output logic              req_o,
  output logic [DATA_W-1:0] q_o,
  output logic              done_o
);

  logic              start_q, start_d;
  logic              pending_q, pending_d;
  logic              aborted_q, aborted_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] q_q, q_d;
  logic              rise;
  logic              deliver;

  assign rise    = start_i & ~start_q;
  // A pending request only stays eligible while the requester still holds start.
  assign req_o   = start_i & (rise | pending_q);
  assign deliver = complete_i & ~aborted_q & start_i;

  always_comb begin
    start_d   = start_i;
    pending_d = pending_q;
    aborted_d = aborted_q;
    if (grant_i || !start_i) begin
      pending_d = 1'b0;
    end else if (rise) begin
      pending_d = 1'b1;
    end
    if (grant_i) begin
      aborted_d = 1'b0;
    end else if (active_i && !start_i) begin
      aborted_d = 1'b1;
    end
    done_d = deliver;
    q_d    = (deliver && rd_i) ? l2_q_i : q_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      start_q   <= 1'b0;
      pending_q <= 1'b0;
      aborted_q <= 1'b0;
      done_q    <= 1'b0;
      q_q       <= '0;
    end else begin
      start_q   <= start_d;
      pending_q <= pending_d;
      aborted_q <= aborted_d;
      done_q    <= done_d;
      q_q       <= q_d;
    end
  end

  assign q_o    = q_q;
  assign done_o = done_q;

endmodule

// File: rtl/l2_arbiter.sv
// Round-robin arbiter sharing one L2 cache bus between instruction fetch (A)
// and data access (B); all l2_* outputs are registered.
module l2_arbiter
  import l2_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [DATA_W-1:0] a_data_i,
  input  logic              a_we_i,
  input  logic              a_start_i,
  output logic [DATA_W-1:0] a_q_o,
  output logic              a_done_o,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic [DATA_W-1:0] b_data_i,
  input  logic              b_we_i,
  input  logic              b_start_i,
  output logic [DATA_W-1:0] b_q_o,
  output logic              b_done_o,
  output logic [ADDR_W-1:0] l2_addr_o,
  output logic [DATA_W-1:0] l2_data_o,
  output logic              l2_we_o,
  output logic              l2_start_o,
  input  logic [DATA_W-1:0] l2_q_i,
  input  logic              l2_done_i
);

  state_e            state_q;
  logic              last_q;
  logic              l2_start_q, l2_we_q;
  logic [ADDR_W-1:0] l2_addr_q;
  logic [DATA_W-1:0] l2_data_q;
  logic              req_a, req_b, arb_en, sel_a, sel_b;
  logic              act_a, act_b, cpl_a, cpl_b;

  // RELEASE arbitrates like IDLE, so back-to-back grants see exactly one low cycle on l2_start.
  assign arb_en = (state_q == ST_IDLE) || (state_q == ST_RELEASE);
  assign sel_a  = arb_en && req_a && (!req_b || last_q == PORT_B);
  assign sel_b  = arb_en && req_b && !sel_a;
  assign act_a  = (state_q == ST_GRANT_A);
  assign act_b  = (state_q == ST_GRANT_B);
  assign cpl_a  = act_a && l2_done_i;
  assign cpl_b  = act_b && l2_done_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      last_q     <= PORT_B;
      l2_start_q <= 1'b0;
      l2_we_q    <= 1'b0;
      l2_addr_q  <= '0;
      l2_data_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_RELEASE: begin
          if (sel_a) begin
            l2_addr_q  <= a_addr_i;
            l2_data_q  <= a_data_i;
            l2_we_q    <= a_we_i;
            l2_start_q <= 1'b1;
            state_q    <= ST_GRANT_A;
          end else if (sel_b) begin
            l2_addr_q  <= b_addr_i;
            l2_data_q  <= b_data_i;
            l2_we_q    <= b_we_i;
            l2_start_q <= 1'b1;
            state_q    <= ST_GRANT_B;
          end else begin
            state_q    <= ST_IDLE;
          end
        end
        ST_GRANT_A: begin
          if (l2_done_i) begin
            l2_start_q <= 1'b0;
            last_q     <= PORT_A;
            state_q    <= ST_RELEASE;
          end
        end
        ST_GRANT_B: begin
          if (l2_done_i) begin
            l2_start_q <= 1'b0;
            last_q     <= PORT_B;
            state_q    <= ST_RELEASE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  l2_arb_port #(.DATA_W(DATA_W)) u_port_a (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (a_start_i),
    .grant_i    (sel_a),
    .active_i   (act_a),
    .complete_i (cpl_a),
    .rd_i       (!l2_we_q),
    .l2_q_i     (l2_q_i),
    .req_o      (req_a),
    .q_o        (a_q_o),
    .done_o     (a_done_o)
  );

  l2_arb_port #(.DATA_W(DATA_W)) u_port_b (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (b_start_i),
    .grant_i    (sel_b),
    .active_i   (act_b),
    .complete_i (cpl_b),
    .rd_i       (!l2_we_q),
    .l2_q_i     (l2_q_i),
    .req_o      (req_b),
    .q_o        (b_q_o),
    .done_o     (b_done_o)
  );

  assign l2_addr_o  = l2_addr_q;
  assign l2_data_o  = l2_data_q;
  assign l2_we_o    = l2_we_q;
  assign l2_start_o = l2_start_q;

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed bench for l2_arbiter with a fixed-latency L2 responder model.
module tb_l2_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] a_addr = '0, b_addr = '0;
  logic [31:0] a_data = '0, b_data = '0;
  logic        a_we = 1'b0, b_we = 1'b0, a_start = 1'b0, b_start = 1'b0;
  logic [31:0] a_q, b_q;
  logic        a_done, b_done;
  logic [23:0] l2_addr;
  logic [31:0] l2_data;
  logic        l2_we, l2_start;
  logic [31:0] l2_q = '0;
  logic        l2_done = 1'b0;

  int errors = 0;
  int checks = 0;

  // L2 responder: raises l2_done once, l2_lat cycles after l2_start rises
  int          l2_lat = 5;
  logic [31:0] l2_rdata = '0;
  int          cnt = 0;
  int          low_cnt = 0;
  int          last_gap = 0;
  logic        prev_start = 1'b0;
  logic [24:0] grant_log[$];

  int a_done_cnt = 0, b_done_cnt = 0, both_cnt = 0;

  always #5 clk = ~clk;

  l2_arbiter dut (
    .clk_i(clk), .rst_ni(rst_n),
    .a_addr_i(a_addr), .a_data_i(a_data), .a_we_i(a_we), .a_start_i(a_start),
    .a_q_o(a_q), .a_done_o(a_done),
    .b_addr_i(b_addr), .b_data_i(b_data), .b_we_i(b_we), .b_start_i(b_start),
    .b_q_o(b_q), .b_done_o(b_done),
    .l2_addr_o(l2_addr), .l2_data_o(l2_data), .l2_we_o(l2_we), .l2_start_o(l2_start),
    .l2_q_i(l2_q), .l2_done_i(l2_done)
  );

  always @(negedge clk) begin
    if (!rst_n) begin
      cnt = 0;
      l2_done = 1'b0;
      prev_start = 1'b0;
    end else begin
      l2_done = 1'b0;
      if (l2_start && !prev_start) begin
        grant_log.push_back({l2_we, l2_addr});
        last_gap = low_cnt;
        low_cnt = 0;
        cnt = 0;
      end
      if (!l2_start) low_cnt++;
      if (l2_start && cnt < l2_lat) begin
        cnt++;
        if (cnt == l2_lat) begin
          l2_done = 1'b1;
          l2_q = l2_rdata;
        end
      end
      prev_start = l2_start;
    end
  end

  always @(negedge clk) begin
    if (a_done) a_done_cnt++;
    if (b_done) b_done_cnt++;
    if (a_done && b_done) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag, input logic port_b, input int budget, output int cycles);
    logic seen;
    seen = 1'b0;
    cycles = 0;
    while (!seen && cycles < budget) begin
      tick();
      cycles++;
      seen = port_b ? b_done : a_done;
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_l2_start"}, 32'(l2_start), 32'd0);
    chk({tag, "_l2_we"},    32'(l2_we),    32'd0);
    chk({tag, "_l2_addr"},  32'(l2_addr),  32'd0);
    chk({tag, "_l2_data"},  l2_data,       32'd0);
    chk({tag, "_a_done"},   32'(a_done),   32'd0);
    chk({tag, "_b_done"},   32'(b_done),   32'd0);
    chk({tag, "_a_q"},      a_q,           32'd0);
    chk({tag, "_b_q"},      b_q,           32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, n0, na, nb, hi;
    logic stable;

    // Reset state
    tick();
    chk_reset_outputs("rst");
    tick();
    rst_n = 1'b1;
    tick();

    // Port A read, 5-cycle L2 latency
    l2_lat = 5; l2_rdata = 32'hDEADBEEF;
    nb = b_done_cnt; na = a_done_cnt;
    a_addr = 24'h000123; a_we = 1'b0; a_start = 1'b1;
    chk("rd_start_before_edge", 32'(l2_start), 32'd0);
    tick();
    chk("rd_start_after_edge", 32'(l2_start), 32'd1);
    chk("rd_l2_addr", 32'(l2_addr), 32'h000123);
    chk("rd_l2_we", 32'(l2_we), 32'd0);
    wait_done("rd_a_done_seen", 1'b0, 20, cyc);
    chk("rd_done_latency", 32'(cyc), 32'd5);
    chk("rd_a_q", a_q, 32'hDEADBEEF);
    chk("rd_l2_start_dropped", 32'(l2_start), 32'd0);
    tick();
    chk("rd_a_done_pulse_end", 32'(a_done), 32'd0);
    chk("rd_a_done_count", 32'(a_done_cnt - na), 32'd1);
    chk("rd_b_done_quiet", 32'(b_done_cnt - nb), 32'd0);
    a_start = 1'b0;
    tick();

    // Simultaneous requests after reset: A first, then B
    do_reset();
    l2_lat = 2; l2_rdata = 32'h22222222;
    n0 = grant_log.size();
    a_addr = 24'h000A00; b_addr = 24'h000B00;
    a_start = 1'b1; b_start = 1'b1;
    wait_done("tie_a_done_seen", 1'b0, 20, cyc);
    chk("tie_a_q", a_q, 32'h22222222);
    wait_done("tie_b_done_seen", 1'b1, 20, cyc);
    chk("tie_b_q", b_q, 32'h22222222);
    a_start = 1'b0; b_start = 1'b0;
    tick();
    chk("tie_grant_count", 32'(grant_log.size() - n0), 32'd2);
    if (grant_log.size() >= n0 + 2) begin
      chk("tie_first_grant", 32'(grant_log[n0]), 32'h0000A00);
      chk("tie_second_grant", 32'(grant_log[n0+1]), 32'h0000B00);
    end
    chk("tie_release_gap", 32'(last_gap), 32'd1);

    // B streams requests while A waits: B, A, B, B
    l2_lat = 3; l2_rdata = 32'h33330003;
    n0 = grant_log.size();
    b_addr = 24'h0B0001; b_start = 1'b1;
    tick();
    a_addr = 24'h0A0003; a_start = 1'b1;
    wait_done("rr_b1_done_seen", 1'b1, 20, cyc);
    b_start = 1'b0;
    tick();
    b_addr = 24'h0B0002; b_start = 1'b1;
    wait_done("rr_a_done_seen", 1'b0, 20, cyc);
    chk("rr_a_q", a_q, 32'h33330003);
    a_start = 1'b0;
    wait_done("rr_b2_done_seen", 1'b1, 20, cyc);
    b_start = 1'b0;
    tick();
    b_addr = 24'h0B0003; b_start = 1'b1;
    wait_done("rr_b3_done_seen", 1'b1, 20, cyc);
    b_start = 1'b0;
    tick();
    chk("rr_grant_count", 32'(grant_log.size() - n0), 32'd4);
    if (grant_log.size() >= n0 + 4) begin
      chk("rr_grant0_b", 32'(grant_log[n0]),   32'h00B0001);
      chk("rr_grant1_a", 32'(grant_log[n0+1]), 32'h00A0003);
      chk("rr_grant2_b", 32'(grant_log[n0+2]), 32'h00B0002);
      chk("rr_grant3_b", 32'(grant_log[n0+3]), 32'h00B0003);
    end

    // Port B write: bus stable until done, b_q untouched
    l2_lat = 4; l2_rdata = 32'h11111111;
    b_addr = 24'h7FFFFC; b_data = 32'h00CAFE00; b_we = 1'b1; b_start = 1'b1;
    tick();
    chk("wr_l2_we", 32'(l2_we), 32'd1);
    chk("wr_l2_data", l2_data, 32'h00CAFE00);
    chk("wr_l2_addr", 32'(l2_addr), 32'h7FFFFC);
    stable = 1'b1;
    cyc = 0;
    while (!b_done && cyc < 20) begin
      if (l2_start && (l2_we !== 1'b1 || l2_data !== 32'h00CAFE00 || l2_addr !== 24'h7FFFFC))
        stable = 1'b0;
      tick();
      cyc++;
    end
    chk("wr_b_done_seen", 32'(b_done), 32'd1);
    chk("wr_bus_stable", 32'(stable), 32'd1);
    chk("wr_b_q_kept", b_q, 32'h33330003);
    b_start = 1'b0; b_we = 1'b0; b_data = '0;
    tick();

    // Abort: A drops start two cycles into its grant
    l2_lat = 6; l2_rdata = 32'h55555555;
    na = a_done_cnt;
    a_addr = 24'h000555; a_start = 1'b1;
    tick();
    chk("ab_granted", 32'(l2_start), 32'd1);
    tick();
    tick();
    a_start = 1'b0;
    hi = 2;
    while (l2_start && hi < 20) begin
      tick();
      hi++;
    end
    chk("ab_start_held_until_done", 32'(hi), 32'd6);
    tick();
    tick();
    chk("ab_no_a_done", 32'(a_done_cnt - na), 32'd0);
    chk("ab_a_q_kept", a_q, 32'h33330003);
    l2_lat = 2; l2_rdata = 32'h0B0B0B0B;
    b_addr = 24'h000BBB; b_start = 1'b1;
    wait_done("ab_b_done_seen", 1'b1, 20, cyc);
    chk("ab_b_q", b_q, 32'h0B0B0B0B);
    b_start = 1'b0;
    tick();

    // Reset in the middle of a B grant
    l2_lat = 8; l2_rdata = 32'h99999999;
    nb = b_done_cnt;
    b_addr = 24'h000999; b_start = 1'b1;
    tick();
    tick();
    chk("mid_in_grant", 32'(l2_start), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid");
    b_start = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    l2_lat = 3; l2_rdata = 32'h77777777;
    a_addr = 24'h000777; a_start = 1'b1;
    wait_done("post_a_done_seen", 1'b0, 20, cyc);
    chk("post_a_q", a_q, 32'h77777777);
    a_start = 1'b0;
    tick();
    chk("post_no_b_done", 32'(b_done_cnt - nb), 32'd0);
    chk("never_both_done", 32'(both_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
